// File: rtl/wb_interconnect_n_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wb_interconnect_n_pkg
// Purpose  : Shared types and default address map for the Wishbone
//            single-master, N-slave interconnect.
// Revision : 1.0 - initial release
// ============================================================================
package wb_interconnect_n_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_ERR  = 2'd2
    } state_t;

    localparam logic [31:0] C_RAM_BASE   = 32'h0000_0000;
    localparam logic [31:0] C_RAM_MASK   = 32'hFFFE_0000;
    localparam logic [31:0] C_UART_BASE  = 32'h8000_0000;
    localparam logic [31:0] C_UART_MASK  = 32'hFFFF_F000;
    localparam logic [31:0] C_I2C_BASE   = 32'h8000_1000;
    localparam logic [31:0] C_I2C_MASK   = 32'hFFFF_F000;
    localparam logic [31:0] C_CLINT_BASE = 32'h8000_2000;
    localparam logic [31:0] C_CLINT_MASK = 32'hFFFF_F000;

    // Packed with device 0 in the least-significant word
    localparam logic [127:0] C_DEF_BASE_ADDR = {C_CLINT_BASE, C_I2C_BASE, C_UART_BASE, C_RAM_BASE};
    localparam logic [127:0] C_DEF_ADDR_MASK = {C_CLINT_MASK, C_I2C_MASK, C_UART_MASK, C_RAM_MASK};

    localparam int C_DEF_TIMEOUT = 255;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wb_interconnect_n_if.sv
`default_nettype none
// ============================================================================
// Module   : wb_interconnect_n_if
// Purpose  : Master-side and device-side Wishbone bundle of the interconnect.
// Revision : 1.0 - initial release
// ============================================================================
interface wb_interconnect_n_if #(
    parameter int N_DEV = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
);
    logic                  i_wb_cyc;
    logic                  i_wb_stb;
    logic                  i_wb_we;
    logic [AW-1:0]         i_wb_addr;
    logic [DW-1:0]         i_wb_data;
    logic [DW/8-1:0]       i_wb_sel;
    logic                  o_wb_ack;
    logic                  o_wb_err;
    logic                  o_wb_stall;
    logic [DW-1:0]         o_wb_data;

    logic [N_DEV-1:0]      o_dev_wb_cyc;
    logic [N_DEV-1:0]      o_dev_wb_stb;
    logic                  o_dev_wb_we;
    logic [AW-1:0]         o_dev_wb_addr;
    logic [DW-1:0]         o_dev_wb_data;
    logic [DW/8-1:0]       o_dev_wb_sel;
    logic [N_DEV-1:0]      i_dev_wb_ack;
    logic [N_DEV-1:0]      i_dev_wb_stall;
    logic [N_DEV*DW-1:0]   i_dev_wb_data;

    // Interconnect side
    modport slave (
        input  i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_data, i_wb_sel,
        output o_wb_ack, o_wb_err, o_wb_stall, o_wb_data,
        output o_dev_wb_cyc, o_dev_wb_stb, o_dev_wb_we, o_dev_wb_addr,
        output o_dev_wb_data, o_dev_wb_sel,
        input  i_dev_wb_ack, i_dev_wb_stall, i_dev_wb_data
    );

    // Environment side: core master plus the attached devices
    modport master (
        output i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_data, i_wb_sel,
        input  o_wb_ack, o_wb_err, o_wb_stall, o_wb_data,
        input  o_dev_wb_cyc, o_dev_wb_stb, o_dev_wb_we, o_dev_wb_addr,
        input  o_dev_wb_data, o_dev_wb_sel,
        output i_dev_wb_ack, i_dev_wb_stall, i_dev_wb_data
    );

endinterface
`default_nettype wire

// File: rtl/wb_interconnect_n_addr_match.sv
`default_nettype none
// ============================================================================
// Module   : wb_addr_match
// Purpose  : Priority base/mask address decoder; lowest device index wins.
// Revision : 1.0 - initial release
// ============================================================================
module wb_addr_match #(
    parameter int                  N_DEV     = 4,
    parameter int                  AW        = 32,
    parameter int                  IW        = 2,
    parameter logic [N_DEV*AW-1:0] BASE_ADDR = '0,
    parameter logic [N_DEV*AW-1:0] ADDR_MASK = '0
) (
    input  logic [AW-1:0]    i_addr,
    output logic [N_DEV-1:0] o_hit,
    output logic [IW-1:0]    o_idx,
    output logic             o_miss
);

    // Scanning from the top down lets lower indices overwrite higher ones
    always_comb begin
        o_hit  = '0;
        o_idx  = '0;
        o_miss = 1'b1;
        for (int k = N_DEV - 1; k >= 0; k--) begin
            if ((i_addr & ADDR_MASK[k*AW +: AW]) ==
                (BASE_ADDR[k*AW +: AW] & ADDR_MASK[k*AW +: AW])) begin
                o_hit    = '0;
                o_hit[k] = 1'b1;
                o_idx    = IW'(k);
                o_miss   = 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/wb_interconnect_n.sv
`default_nettype none
// ============================================================================
// Module   : wb_interconnect_n
// Purpose  : Pipelined Wishbone 1-master/N-slave interconnect with address
//            decode, single outstanding transaction, unmapped/timeout errors.
// Revision : 1.0 - initial release
// ============================================================================
module wb_interconnect_n
    import wb_interconnect_n_pkg::*;
#(
    parameter int                  N_DEV     = 4,
    parameter int                  AW        = 32,
    parameter int                  DW        = 32,
    parameter logic [N_DEV*AW-1:0] BASE_ADDR = C_DEF_BASE_ADDR,
    parameter logic [N_DEV*AW-1:0] ADDR_MASK = C_DEF_ADDR_MASK,
    parameter int                  TIMEOUT   = C_DEF_TIMEOUT
) (
    input  logic               i_clk,
    input  logic               i_rst,
    wb_interconnect_n_if.slave bus
);

    localparam int IW = idx_width(N_DEV);
    localparam int TW = $clog2(TIMEOUT + 1);

    state_t          state_q;
    logic [IW-1:0]   sel_q;
    logic [TW-1:0]   timer_q;
    logic [TW-1:0]   timer_d;

    logic [N_DEV-1:0] w_hit;
    logic [IW-1:0]    w_idx;
    logic             w_miss;
    logic             w_req;
    logic             w_hit_stall;
    logic             w_accept;
    logic             w_dev_ack;
    logic [DW-1:0]    w_dev_data;
    logic             w_timeout;

    logic [N_DEV-1:0] w_cyc;
    logic [N_DEV-1:0] w_stb;
    logic             w_ack;
    logic             w_err;
    logic             w_stall;
    logic [DW-1:0]    w_rdata;

    wb_addr_match #(
        .N_DEV     (N_DEV),
        .AW        (AW),
        .IW        (IW),
        .BASE_ADDR (BASE_ADDR),
        .ADDR_MASK (ADDR_MASK)
    ) u_match (
        .i_addr (bus.i_wb_addr),
        .o_hit  (w_hit),
        .o_idx  (w_idx),
        .o_miss (w_miss)
    );

    assign w_req       = bus.i_wb_cyc & bus.i_wb_stb;
    assign w_hit_stall = |(w_hit & bus.i_dev_wb_stall);
    assign w_accept    = (state_q == ST_IDLE) & w_req & ~w_hit_stall;
    assign w_dev_ack   = bus.i_dev_wb_ack[sel_q];
    assign w_dev_data  = bus.i_dev_wb_data[int'(sel_q)*DW +: DW];
    assign timer_d     = timer_q + 1'b1;
    assign w_timeout   = (timer_d == TW'(TIMEOUT));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
            timer_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (w_accept) begin
                        if (w_miss) begin
                            state_q <= ST_ERR;
                        end else begin
                            state_q <= ST_BUSY;
                            sel_q   <= w_idx;
                            timer_q <= '0;
                        end
                    end
                end
                ST_BUSY: begin
                    if (!bus.i_wb_cyc || w_dev_ack || w_timeout) begin
                        state_q <= ST_IDLE;
                    end else begin
                        timer_q <= timer_d;
                    end
                end
                ST_ERR:  state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // A device ack arriving in the timeout cycle still completes normally
    always_comb begin
        w_cyc   = '0;
        w_stb   = '0;
        w_ack   = 1'b0;
        w_err   = 1'b0;
        w_stall = 1'b0;
        w_rdata = '0;
        case (state_q)
            ST_IDLE: begin
                w_stall = w_hit_stall;
                if (!i_rst && w_req) begin
                    w_cyc = w_hit;
                    w_stb = w_hit;
                end
            end
            ST_BUSY: begin
                w_stall = 1'b1;
                if (bus.i_wb_cyc) begin
                    if (w_dev_ack) begin
                        w_ack        = 1'b1;
                        w_rdata      = w_dev_data;
                        w_cyc[sel_q] = 1'b1;
                    end else if (w_timeout) begin
                        w_ack = 1'b1;
                        w_err = 1'b1;
                    end else begin
                        w_cyc[sel_q] = 1'b1;
                    end
                end
            end
            ST_ERR: begin
                w_stall = 1'b1;
                w_ack   = bus.i_wb_cyc;
                w_err   = bus.i_wb_cyc;
            end
            default: begin
                w_stall = 1'b1;
            end
        endcase
    end

    assign bus.o_wb_ack      = w_ack;
    assign bus.o_wb_err      = w_err;
    assign bus.o_wb_stall    = w_stall;
    assign bus.o_wb_data     = w_rdata;
    assign bus.o_dev_wb_cyc  = w_cyc;
    assign bus.o_dev_wb_stb  = w_stb;
    assign bus.o_dev_wb_we   = bus.i_wb_we;
    assign bus.o_dev_wb_addr = bus.i_wb_addr;
    assign bus.o_dev_wb_data = bus.i_wb_data;
    assign bus.o_dev_wb_sel  = bus.i_wb_sel;

endmodule
`default_nettype wire

// File: doc/wb_interconnect_n.md
# wb_interconnect_n

Parametrised Wishbone (pipelined) single-master, N-slave interconnect placed between the core's data port and the memory-mapped devices (RAM, UART, I2C, CLINT). It decodes the address against a programmable base/mask map, steers the request to one device, routes ack/data back, and tracks the one outstanding transaction. Unmapped addresses and hung devices terminate with a bus error instead of deadlocking the core.

## Interface
- N_DEV, 4, number of slave devices (1..16)
- AW, 32, address width
- DW, 32, data width (multiple of 8)
- BASE_ADDR, {32'h8000_2000, 32'h8000_1000, 32'h8000_0000, 32'h0000_0000}, packed N_DEV×AW device base addresses, dev0 in LSBs
- ADDR_MASK, {32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFE_0000}, packed N_DEV×AW match masks
- TIMEOUT, 255, cycles before a hung request is terminated (≥2)

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset, asynchronous, active-high
- i_wb_cyc, i_wb_stb, i_wb_we  in  1  master cycle, strobe, write-enable
- i_wb_addr  in  AW  master address
- i_wb_data  in  DW  master write data
- i_wb_sel  in  DW/8  byte strobes
- o_wb_ack  out  1  transaction complete
- o_wb_err  out  1  error qualifier, valid only with o_wb_ack
- o_wb_stall  out  1  request not accepted
- o_wb_data  out  DW  read data
- o_dev_wb_cyc, o_dev_wb_stb  out  N_DEV  per-device cycle, strobe
- o_dev_wb_we  out  1  broadcast write-enable
- o_dev_wb_addr  out  AW  broadcast address (full, unmasked)
- o_dev_wb_data  out  DW  broadcast write data
- o_dev_wb_sel  out  DW/8  broadcast byte strobes
- i_dev_wb_ack, i_dev_wb_stall  in  N_DEV  per-device ack, stall
- i_dev_wb_data  in  N_DEV×DW  packed read data, dev0 in LSBs

## Operation
- Hit for device k: (i_wb_addr & MASK[k]) == (BASE[k] & MASK[k]); lowest index wins on overlap; no hit → unmapped.
- FSM states IDLE, BUSY, ERR.
- IDLE: o_dev_wb_cyc[k]/stb[k] = i_wb_cyc & i_wb_stb & hit[k] (combinational); o_wb_stall = i_dev_wb_stall[hit] for a hit, 0 for unmapped. Accept = cyc & stb & !o_wb_stall.
  - Accept, hit → latch index, clear timer, → BUSY.
  - Accept, unmapped → ERR.
- BUSY: o_wb_stall=1; o_dev_wb_cyc[sel]=i_wb_cyc, stb=0; o_wb_ack=i_dev_wb_ack[sel], o_wb_data=i_dev_wb_data[sel] (combinational pass-through). Ack → IDLE. Timer reaches TIMEOUT without ack → o_wb_ack=1, o_wb_err=1 for one cycle, device cyc dropped, → IDLE.
- ERR: o_wb_ack=1, o_wb_err=1, o_wb_data=0, o_wb_stall=1 for one cycle → IDLE.
- i_wb_cyc low in BUSY/ERR: abort, no ack to master, → IDLE next cycle.
- Acks from non-selected devices, or any ack in IDLE, ignored.
- o_wb_data = 0 whenever o_wb_ack is low.

## Timing
- Reset: state IDLE, timer 0, latched index 0; o_wb_ack, o_wb_err 0, o_wb_data 0; all o_dev_wb_cyc/stb 0.
- Zero added latency on hits: device ack at cycle t appears on o_wb_ack at t.
- Devices ack no earlier than the cycle after the accepting strobe; an ack in the accept cycle is ignored.
- Unmapped: ack+err exactly 1 cycle after accept.
- Timeout: ack+err exactly TIMEOUT cycles after accept; device ack in that same cycle wins (err=0).
- Back-to-back: new request may be accepted in the cycle after ack (IDLE), giving 1 transaction per 2 cycles on 1-cycle devices.
- Reset asserted mid-transaction: immediate return to IDLE, all outputs to reset values, pending ack discarded.

## Structure
- Shared package: state encoding localparams, default address map constants (RAM/UART/I2C/CLINT base and mask), default TIMEOUT.
- Sub-module wb_addr_match: combinational priority decoder producing one-hot hit vector and miss flag from address, BASE_ADDR, ADDR_MASK.
- Timer width $clog2(TIMEOUT+1).

## Test plan
- Read 0x0000_0100 with dev0 acking 1 cycle later, data 0xDEAD_BEEF → o_wb_data=0xDEAD_BEEF, err=0, only o_dev_wb_cyc[0] ever high.
- Write 0x8000_1004, sel=4'b0011, dev2 stalls 3 cycles → o_wb_stall high 3 cycles, one stb to dev2 after stall drops, ack forwarded.
- Read 0x4000_0000 (unmapped) → ack+err 1 cycle after accept, data 0, no device cyc.
- Write 0x8000_0000, dev1 never acks, TIMEOUT=255 → ack+err at cycle 255, dev1 cyc dropped; next access to dev0 succeeds.
- Overlapping map (dev1 base=dev0 base) → dev0 selected.
- i_wb_cyc dropped in BUSY, dev0 acks next cycle → no o_wb_ack; i_rst pulsed in BUSY → IDLE, outputs zero.
